instr_fetch_unit: RTL and testbench
===================================

# instr_fetch_unit

Instruction fetch stage of the MIPS datapath, directly upstream of `Control_Unit`. It holds the program counter and requests one instruction word per step from instruction memory over a request/acknowledge handshake. It presents the decoded fields (`op_out`, `func_out` and the others) to the control unit and register file. When the downstream datapath commits, it selects the next PC from the `branch` and `jump` decisions fed back from the control unit and ALU.

## Interface
- `RESET_PC`, 32'h0000_0000, PC value loaded on reset; must be word-aligned.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `imem_req`  out  1  fetch request; held high until acknowledged.
- `imem_addr`  out  32  byte address of the requested word; equals `pc`.
- `imem_ack`  in  1  memory has `imem_rdata` valid this cycle; ignored unless `imem_req`=1.
- `imem_rdata`  in  32  instruction word.
- `stall`  in  1  downstream not ready to commit the presented instruction.
- `branch`  in  1  from control unit: instruction is BEQ.
- `jump`  in  1  from control unit: instruction is J.
- `zero`  in  1  ALU zero flag.
- `instr_valid`  out  1  `instr` and its fields are valid and held stable.
- `instr`  out  32  captured instruction word.
- `op_out`  out  6  `instr[31:26]`.
- `func_out`  out  6  `instr[5:0]`.
- `rs_out`, `rt_out`, `rd_out`  out  5 each  `instr[25:21]`, `instr[20:16]`, `instr[15:11]`.
- `imm_out`  out  16  `instr[15:0]`.
- `pc`  out  32  address of the current instruction.
- `pc_plus4`  out  32  `pc + 4`, mod 2^32.
- `retired`  out  32  count of committed instructions.

## Operation
- States: FETCH and ISSUE (2-state FSM).
- Reset: `rst`=1 in a cycle forces the following state on the next edge, regardless of current state:
  - state = FETCH, `pc` = `RESET_PC`, `instr` = 0, `retired` = 0.
  - `imem_req` = 0 and `instr_valid` = 0 while `rst` is high.
- FETCH:
  - Drive `imem_req`=1 and `imem_addr`=`pc`.
  - On `imem_ack`=1, capture `imem_rdata` into `instr` and go to ISSUE. Otherwise stay in FETCH with `imem_req` held.
- ISSUE:
  - Drive `instr_valid`=1; `instr` and all field outputs are stable.
  - `imem_req`=0, and any `imem_ack` is ignored.
  - If `stall`=1, stay in ISSUE.
  - If `stall`=0, commit: `pc` ← next PC, `retired` ← `retired`+1 (wraps at 2^32), go to FETCH.
- Next PC, sampled in the commit cycle, in priority order:
  - `jump`=1: `{pc_plus4[31:28], instr[25:0], 2'b00}`.
  - else `branch`=1 and `zero`=1: `pc_plus4 + (sign_extend(imm_out) << 2)`, mod 2^32.
  - else: `pc_plus4`.
- Simultaneous `jump` and `branch`: jump wins.
- `branch`, `jump` and `zero` are don't-care outside the commit cycle.
- `instr` = 0 (the NOP encoding) decodes as no-op downstream. The fetch unit treats it like any other word and commits it normally.
- PC arithmetic wraps silently: `pc`=32'hFFFF_FFFC with sequential flow gives next PC 0.

## Timing
- Zero-wait memory (`imem_ack` in the same cycle as `imem_req`): 2 cycles per instruction.
  - Cycle N: FETCH, ack.
  - Cycle N+1: ISSUE, commit.
  - Cycle N+2: next request.
- Each wait cycle of memory and each cycle of `stall` adds exactly one cycle.
- First `imem_req` is asserted in the first cycle after `rst` deasserts.
- `instr_valid` rises exactly one cycle after the accepting `imem_ack`.
- Fields are registered: the output values do not change while `instr_valid`=1.
- `imem_addr` is stable for the whole time `imem_req` is high.
- Reset asserted mid-fetch or mid-stall: the pending request or instruction is abandoned, and no commit occurs.

## Structure
- Shared package `mips_pkg` holds:
  - opcode and funct constants (ADD, SUB, AND, OR, SLT, ADDI, LW, SW, BEQ, J);
  - the instruction field bit positions;
  - the fetch state enum {FETCH, ISSUE}.
- Sub-module `fetch_next_pc` (combinational): inputs `pc_plus4`, `instr`, `branch`, `jump`, `zero`; output next PC.
- PC, instruction register, FSM and retire counter stay in the top module.

## Test plan
- Reset with `RESET_PC`=0, zero-wait memory returning sequential ADDs → `imem_addr` = 0, 4, 8, 12 on every other cycle; `retired`=4 after 8 cycles.
- `imem_ack` delayed 3 cycles at `pc`=0x10 → `imem_req` and `imem_addr`=0x10 held for 4 cycles; `instr_valid` rises the cycle after the ack.
- BEQ at 0x20 with imm=0xFFFE, `branch`=1, `zero`=1 → next `imem_addr`=0x1C. Same instruction with `zero`=0 → next address 0x24.
- J at 0x4000_0000 with target field 0x000_0100 → next `imem_addr`=0x4000_0400. With `branch`=1 and `zero`=1 also asserted → jump still taken.
- `stall` high for 5 cycles in ISSUE → `instr` stable, `pc` and `retired` unchanged, no `imem_req` asserted; commit on the first cycle `stall`=0.
- `rst` pulsed while in FETCH with a pending request at 0x30 → next cycle `imem_req`=0, `pc`=`RESET_PC`, `retired`=0. A late `imem_ack` arriving during reset is ignored.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS definitions: opcodes, funct codes, field positions and fetch state.
package mips_pkg;

  // Primary opcodes
  localparam logic [5:0] OpRtype = 6'h00;
  localparam logic [5:0] OpAddi  = 6'h08;
  localparam logic [5:0] OpLw    = 6'h23;
  localparam logic [5:0] OpSw    = 6'h2b;
  localparam logic [5:0] OpBeq   = 6'h04;
  localparam logic [5:0] OpJ     = 6'h02;

  // R-type funct codes
  localparam logic [5:0] FunctAdd = 6'h20;
  localparam logic [5:0] FunctSub = 6'h22;
  localparam logic [5:0] FunctAnd = 6'h24;
  localparam logic [5:0] FunctOr  = 6'h25;
  localparam logic [5:0] FunctSlt = 6'h2a;

  // Instruction field bit positions
  localparam int unsigned OpMsb     = 31;
  localparam int unsigned OpLsb     = 26;
  localparam int unsigned RsMsb     = 25;
  localparam int unsigned RsLsb     = 21;
  localparam int unsigned RtMsb     = 20;
  localparam int unsigned RtLsb     = 16;
  localparam int unsigned RdMsb     = 15;
  localparam int unsigned RdLsb     = 11;
  localparam int unsigned ImmMsb    = 15;
  localparam int unsigned ImmLsb    = 0;
  localparam int unsigned FunctMsb  = 5;
  localparam int unsigned FunctLsb  = 0;
  localparam int unsigned TargetMsb = 25;
  localparam int unsigned TargetLsb = 0;

  typedef enum logic [0:0] {
    StFetch,
    StIssue
  } fetch_state_e;

  function automatic logic [31:0] sext_imm(input logic [15:0] imm);
    return {{16{imm[15]}}, imm};
  endfunction

endpackage

// File: rtl/fetch_next_pc.sv
// Next-PC selection for the fetch stage: jump, taken branch, or sequential.
module fetch_next_pc
  import mips_pkg::*;
(
  input  logic [31:0] pc_plus4,
  input  logic [31:0] instr,
  input  logic        branch,
  input  logic        jump,
  input  logic        zero,
  output logic [31:0] next_pc
);

  // Jump has priority over a taken branch; addresses wrap mod 2^32.
  always_comb begin
    next_pc = pc_plus4;
    if (jump) begin
      next_pc = {pc_plus4[31:28], instr[TargetMsb:TargetLsb], 2'b00};
    end else if (branch && zero) begin
      next_pc = pc_plus4 + (sext_imm(instr[ImmMsb:ImmLsb]) << 2);
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: PC, request/ack fetch, instruction register, retire count.
module instr_fetch_unit
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        branch,
  input  logic        jump,
  input  logic        zero,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [5:0]  op_out,
  output logic [5:0]  func_out,
  output logic [4:0]  rs_out,
  output logic [4:0]  rt_out,
  output logic [4:0]  rd_out,
  output logic [15:0] imm_out,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic [31:0] retired
);

  fetch_state_e state_q;
  logic [31:0]  pc_q;
  logic [31:0]  instr_q;
  logic [31:0]  retired_q;
  logic [31:0]  next_pc;

  assign pc        = pc_q;
  assign pc_plus4  = pc_q + 32'd4;
  assign imem_addr = pc_q;
  assign instr     = instr_q;
  assign retired   = retired_q;

  // Handshake outputs decode the state but are forced low for the whole reset cycle.
  assign imem_req    = (state_q == StFetch) && !rst;
  assign instr_valid = (state_q == StIssue) && !rst;

  assign op_out   = instr_q[OpMsb:OpLsb];
  assign func_out = instr_q[FunctMsb:FunctLsb];
  assign rs_out   = instr_q[RsMsb:RsLsb];
  assign rt_out   = instr_q[RtMsb:RtLsb];
  assign rd_out   = instr_q[RdMsb:RdLsb];
  assign imm_out  = instr_q[ImmMsb:ImmLsb];

  fetch_next_pc u_next_pc (
    .pc_plus4 (pc_plus4),
    .instr    (instr_q),
    .branch   (branch),
    .jump     (jump),
    .zero     (zero),
    .next_pc  (next_pc)
  );

  // Fetch/issue FSM with PC, instruction register and retire counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StFetch;
      pc_q      <= RESET_PC;
      instr_q   <= '0;
      retired_q <= '0;
    end else begin
      case (state_q)
        StFetch: begin
          if (imem_ack) begin
            instr_q <= imem_rdata;
            state_q <= StIssue;
          end
        end
        StIssue: begin
          // Ack is ignored here; only the commit moves the PC.
          if (!stall) begin
            pc_q      <= next_pc;
            retired_q <= retired_q + 32'd1;
            state_q   <= StFetch;
          end
        end
        default: state_q <= StFetch;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed self-checking bench for instr_fetch_unit.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        stall;
  logic        branch;
  logic        jump;
  logic        zero;
  logic        instr_valid;
  logic [31:0] instr;
  logic [5:0]  op_out;
  logic [5:0]  func_out;
  logic [4:0]  rs_out;
  logic [4:0]  rt_out;
  logic [4:0]  rd_out;
  logic [15:0] imm_out;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic [31:0] retired;

  logic        auto_ack;
  logic        manual_ack;
  int unsigned total = 0;
  int unsigned bad = 0;
  logic [31:0] exp_ret;

  localparam logic [31:0] AddWord = 32'h0022_1820;  // add $3,$1,$2
  localparam logic [31:0] BeqWord = 32'h1022_FFFE;  // beq $1,$2,-2
  localparam logic [31:0] JTo20   = 32'h0800_0008;  // j 0x20
  localparam logic [31:0] JMax    = 32'h0BFF_FFFF;  // j target 0x3FFFFFF
  localparam logic [31:0] JZero   = 32'h0800_0000;  // j target 0
  localparam logic [31:0] J100    = 32'h0800_0100;  // j target 0x100

  always #5 clk = ~clk;

  // Zero-wait memory when auto_ack is set, otherwise ack is hand driven.
  assign imem_ack = auto_ack ? imem_req : manual_ack;

  instr_fetch_unit #(
    .RESET_PC (32'h0000_0000)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .stall       (stall),
    .branch      (branch),
    .jump        (jump),
    .zero        (zero),
    .instr_valid (instr_valid),
    .instr       (instr),
    .op_out      (op_out),
    .func_out    (func_out),
    .rs_out      (rs_out),
    .rt_out      (rt_out),
    .rd_out      (rd_out),
    .imm_out     (imm_out),
    .pc          (pc),
    .pc_plus4    (pc_plus4),
    .retired     (retired)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One zero-wait fetch plus commit with the given control feedback.
  task automatic run_instr(input logic [31:0] word, input logic j, input logic b,
                           input logic z);
    imem_rdata = word;
    auto_ack   = 1'b1;
    #1;
    check("fetch_req", imem_req, 1);
    tick();
    check("issue_valid", instr_valid, 1);
    check("issue_req", imem_req, 0);
    check("issue_instr", instr, word);
    jump   = j;
    branch = b;
    zero   = z;
    tick();
    jump   = 1'b0;
    branch = 1'b0;
    zero   = 1'b0;
    exp_ret++;
    check("retired", retired, exp_ret);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst        = 1'b1;
    stall      = 1'b0;
    branch     = 1'b0;
    jump       = 1'b0;
    zero       = 1'b0;
    auto_ack   = 1'b0;
    manual_ack = 1'b0;
    imem_rdata = 32'h0;
    exp_ret    = 32'd0;

    // Reset state
    tick();
    tick();
    check("rst_req", imem_req, 0);
    check("rst_valid", instr_valid, 0);
    check("rst_pc", pc, 32'h0);
    check("rst_retired", retired, 32'h0);
    check("rst_instr", instr, 32'h0);
    rst = 1'b0;
    #1;
    check("first_req", imem_req, 1);
    check("first_addr", imem_addr, 32'h0);

    // Sequential zero-wait flow
    for (int i = 0; i < 4; i++) begin
      check("seq_addr", imem_addr, 32'(4 * i));
      run_instr(AddWord, 1'b0, 1'b0, 1'b0);
    end
    check("seq_retired", retired, 32'd4);
    check("seq_pc", pc, 32'h10);

    // Memory ack delayed 3 cycles at 0x10; the word is a jump to 0x20
    auto_ack   = 1'b0;
    manual_ack = 1'b0;
    imem_rdata = JTo20;
    for (int k = 0; k < 3; k++) begin
      check("wait_req", imem_req, 1);
      check("wait_addr", imem_addr, 32'h10);
      check("wait_valid", instr_valid, 0);
      tick();
    end
    manual_ack = 1'b1;
    #1;
    check("ack_req", imem_req, 1);
    check("ack_addr", imem_addr, 32'h10);
    tick();
    manual_ack = 1'b0;
    check("ack_valid", instr_valid, 1);
    check("ack_instr", instr, JTo20);
    jump = 1'b1;
    tick();
    jump = 1'b0;
    exp_ret++;
    check("j20_addr", imem_addr, 32'h20);

    // BEQ taken / not taken at 0x20
    run_instr(BeqWord, 1'b0, 1'b1, 1'b1);
    check("beq_taken", imem_addr, 32'h1C);
    run_instr(JTo20, 1'b1, 1'b0, 1'b0);
    check("back_to_20", imem_addr, 32'h20);
    run_instr(BeqWord, 1'b0, 1'b1, 1'b0);
    check("beq_not_taken", imem_addr, 32'h24);
    for (int i = 0; i < 3; i++) run_instr(AddWord, 1'b0, 1'b0, 1'b0);
    check("at_30", imem_addr, 32'h30);

    // Reset with a pending request at 0x30 and a late ack during reset
    auto_ack   = 1'b0;
    manual_ack = 1'b0;
    #1;
    check("pend_req", imem_req, 1);
    tick();
    check("pend_addr", imem_addr, 32'h30);
    rst        = 1'b1;
    manual_ack = 1'b1;
    imem_rdata = 32'hFFFF_FFFF;
    #1;
    check("rst_mid_req", imem_req, 0);
    check("rst_mid_valid", instr_valid, 0);
    tick();
    check("rst_mid_pc", pc, 32'h0);
    check("rst_mid_retired", retired, 32'h0);
    check("rst_mid_instr", instr, 32'h0);
    rst        = 1'b0;
    manual_ack = 1'b0;
    #1;
    check("post_rst_req", imem_req, 1);
    check("post_rst_addr", imem_addr, 32'h0);
    exp_ret = 32'd0;

    // Jump chain climbing 256 MB regions up to 0x4000_0000
    run_instr(JMax, 1'b1, 1'b0, 1'b0);
    check("chain0", imem_addr, 32'h0FFF_FFFC);
    run_instr(JMax, 1'b1, 1'b0, 1'b0);
    check("chain1", imem_addr, 32'h1FFF_FFFC);
    run_instr(JMax, 1'b1, 1'b0, 1'b0);
    check("chain2", imem_addr, 32'h2FFF_FFFC);
    run_instr(JMax, 1'b1, 1'b0, 1'b0);
    check("chain3", imem_addr, 32'h3FFF_FFFC);
    run_instr(JZero, 1'b1, 1'b0, 1'b0);
    check("chain4", imem_addr, 32'h4000_0000);
    run_instr(J100, 1'b1, 1'b0, 1'b0);
    check("j_target", imem_addr, 32'h4000_0400);
    run_instr(JZero, 1'b1, 1'b0, 1'b0);
    check("j_back", imem_addr, 32'h4000_0000);
    run_instr(J100, 1'b1, 1'b1, 1'b1);
    check("j_over_beq", imem_addr, 32'h4000_0400);

    // Stall in ISSUE for 5 cycles; stray ack and data must be ignored
    imem_rdata = AddWord;
    auto_ack   = 1'b1;
    tick();
    auto_ack   = 1'b0;
    manual_ack = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    stall      = 1'b1;
    #1;
    check("fld_op", op_out, 32'h00);
    check("fld_func", func_out, 32'h20);
    check("fld_rs", rs_out, 32'd1);
    check("fld_rt", rt_out, 32'd2);
    check("fld_rd", rd_out, 32'd3);
    check("fld_imm", imm_out, 32'h1820);
    check("fld_pc4", pc_plus4, 32'h4000_0404);
    for (int i = 0; i < 5; i++) begin
      check("stall_instr", instr, AddWord);
      check("stall_valid", instr_valid, 1);
      check("stall_req", imem_req, 0);
      check("stall_pc", pc, 32'h4000_0400);
      check("stall_retired", retired, exp_ret);
      tick();
    end
    stall      = 1'b0;
    manual_ack = 1'b0;
    tick();
    exp_ret++;
    check("unstall_retired", retired, exp_ret);
    check("unstall_addr", imem_addr, 32'h4000_0404);
    check("unstall_req", imem_req, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
